// File: rtl/mr_wb_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mr_wb_arb : writeback arbiter, pipe + CSR result FIFOs -> one RF port     |
// | Revision  : 1.0                                                           |
// +--------------------------------------------------------------------------+
module mr_wb_arb #(
  parameter int XLEN         = 32,
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    pipe_valid,
  output logic                    pipe_ready,
  input  logic [4:0]              pipe_reg,
  input  logic [XLEN-1:0]         pipe_val,
  input  logic                    csr_valid,
  output logic                    csr_ready,
  input  logic [4:0]              csr_reg,
  input  logic [XLEN-1:0]         csr_val,
  output logic                    rf_we,
  output logic [4:0]              rf_waddr,
  output logic [XLEN-1:0]         rf_wdata,
  output logic [1:0]              insts_ret,
  output logic [$clog2(DEPTH):0]  pipe_level,
  output logic [$clog2(DEPTH):0]  csr_level,
  output logic                    idle
);

  localparam int              PW           = $clog2(DEPTH);
  localparam int              LW           = PW + 1;
  localparam logic [LW-1:0]   C_FULL       = LW'(DEPTH);
  localparam logic [3:0]      C_STARVE_MAX = 4'(STARVE_LIMIT);

  // Index 0 is the pipe source, index 1 the CSR source.
  logic [1:0]            w_in_valid;
  logic [1:0][4:0]       w_in_reg;
  logic [1:0][XLEN-1:0]  w_in_val;
  logic [1:0]            w_ready;
  logic [1:0]            w_push;
  logic [1:0]            w_pop;
  logic [1:0]            w_head_v;
  logic [1:0][4:0]       w_head_reg;
  logic [1:0][XLEN-1:0]  w_head_val;
  logic [1:0][LW-1:0]    w_level;
  logic [1:0]            w_null;
  logic [1:0]            w_wr;
  logic                  w_csr_force;
  logic                  w_gnt_pipe;
  logic                  w_gnt_csr;
  logic [3:0]            r_starve;

  assign w_in_valid = {csr_valid, pipe_valid};
  assign w_in_reg   = {csr_reg, pipe_reg};
  assign w_in_val   = {csr_val, pipe_val};

  generate
    for (genvar s = 0; s < 2; s++) begin : g_src
      logic [4:0]      r_reg_mem [DEPTH];
      logic [XLEN-1:0] r_val_mem [DEPTH];
      logic [PW-1:0]   r_wptr;
      logic [PW-1:0]   r_rptr;
      logic [LW-1:0]   r_level;

      always_ff @(posedge clk) begin
        if (w_push[s]) begin
          r_reg_mem[r_wptr] <= w_in_reg[s];
          r_val_mem[r_wptr] <= w_in_val[s];
        end
      end

      // Pointers are exactly PW bits wide, so DEPTH being a power of two gives the wrap for free.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_wptr  <= '0;
          r_rptr  <= '0;
          r_level <= '0;
        end else begin
          if (w_push[s]) r_wptr <= r_wptr + PW'(1);
          if (w_pop[s])  r_rptr <= r_rptr + PW'(1);
          r_level <= r_level + LW'(w_push[s]) - LW'(w_pop[s]);
        end
      end

      assign w_ready[s]    = (r_level < C_FULL);
      assign w_push[s]     = w_in_valid[s] & w_ready[s];
      assign w_level[s]    = r_level;
      assign w_head_v[s]   = (r_level != '0);
      assign w_head_reg[s] = r_reg_mem[r_rptr];
      assign w_head_val[s] = r_val_mem[r_rptr];
    end
  endgenerate

  always_comb begin
    w_null      = '0;
    w_wr        = '0;
    for (int s = 0; s < 2; s++) begin
      w_null[s] = w_head_v[s] && (w_head_reg[s] == 5'd0);
      w_wr[s]   = w_head_v[s] && (w_head_reg[s] != 5'd0);
    end
    // A waiting CSR head overrides pipe priority once starved or when its FIFO is full.
    w_csr_force = (r_starve == C_STARVE_MAX) || (w_level[1] == C_FULL);
    w_gnt_pipe  = w_wr[0] && !(w_wr[1] && w_csr_force);
    w_gnt_csr   = w_wr[1] && !w_gnt_pipe;
    w_pop       = {w_null[1] | w_gnt_csr, w_null[0] | w_gnt_pipe};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we     <= 1'b0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
      insts_ret <= '0;
      r_starve  <= '0;
    end else begin
      rf_we     <= w_gnt_pipe | w_gnt_csr;
      if (w_gnt_csr) begin
        rf_waddr <= w_head_reg[1];
        rf_wdata <= w_head_val[1];
      end else if (w_gnt_pipe) begin
        rf_waddr <= w_head_reg[0];
        rf_wdata <= w_head_val[0];
      end
      insts_ret <= {1'b0, w_pop[0]} + {1'b0, w_pop[1]};
      if (w_pop[1]) begin
        r_starve <= '0;
      end else if (w_wr[1] && (r_starve != C_STARVE_MAX)) begin
        r_starve <= r_starve + 4'd1;
      end
    end
  end

  assign pipe_ready = w_ready[0];
  assign csr_ready  = w_ready[1];
  assign pipe_level = w_level[0];
  assign csr_level  = w_level[1];
  assign idle       = (w_level[0] == '0) && (w_level[1] == '0) && !rf_we;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) begin
      a_pipe_level: assert (pipe_level <= C_FULL);
      a_csr_level:  assert (csr_level <= C_FULL);
      a_ret_max:    assert (insts_ret <= 2'd2);
      a_we_addr:    assert (!rf_we || (rf_waddr != 5'd0));
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mr_wb_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mr_wb_arb : directed self-checking bench for mr_wb_arb                 |
// | Revision     : 1.0                                                        |
// +--------------------------------------------------------------------------+
module tb_mr_wb_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_valid, csr_valid;
  logic        pipe_ready, csr_ready;
  logic [4:0]  pipe_reg, csr_reg;
  logic [31:0] pipe_val, csr_val;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [1:0]  insts_ret;
  logic [1:0]  pipe_level, csr_level;
  logic        idle;

  logic        p4_valid, c4_valid, p4_ready, c4_ready;
  logic [4:0]  p4_reg, c4_reg;
  logic [31:0] p4_val, c4_val;
  logic        rf4_we;
  logic [4:0]  rf4_waddr;
  logic [31:0] rf4_wdata;
  logic [1:0]  ret4;
  logic [2:0]  p4_level, c4_level;
  logic        idle4;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  // Starvation scenario: expected RF writes per cycle.
  logic        st_we   [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [4:0]  st_addr [8] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd9, 5'd4, 5'd5, 5'd0};
  logic [31:0] st_data [8] = '{32'h0, 32'h3000_0000, 32'h3000_0001, 32'h3000_0002,
                               32'hC5C5_0000, 32'h3000_0003, 32'h3000_0004, 32'h0};

  always #5 clk = ~clk;

  mr_wb_arb #(.XLEN(32), .DEPTH(2), .STARVE_LIMIT(3)) u_dut (
    .clk(clk), .rst(rst),
    .pipe_valid(pipe_valid), .pipe_ready(pipe_ready), .pipe_reg(pipe_reg), .pipe_val(pipe_val),
    .csr_valid(csr_valid), .csr_ready(csr_ready), .csr_reg(csr_reg), .csr_val(csr_val),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .insts_ret(insts_ret),
    .pipe_level(pipe_level), .csr_level(csr_level), .idle(idle)
  );

  mr_wb_arb #(.XLEN(32), .DEPTH(4), .STARVE_LIMIT(3)) u_dut4 (
    .clk(clk), .rst(rst),
    .pipe_valid(p4_valid), .pipe_ready(p4_ready), .pipe_reg(p4_reg), .pipe_val(p4_val),
    .csr_valid(c4_valid), .csr_ready(c4_ready), .csr_reg(c4_reg), .csr_val(c4_val),
    .rf_we(rf4_we), .rf_waddr(rf4_waddr), .rf_wdata(rf4_wdata), .insts_ret(ret4),
    .pipe_level(p4_level), .csr_level(c4_level), .idle(idle4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int pi, ci, k;
    logic pr, cr;
    logic        e_we;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    int m_pl, m_cl;

    rst = 1'b1;
    pipe_valid = 1'b0; pipe_reg = '0; pipe_val = '0;
    csr_valid  = 1'b0; csr_reg  = '0; csr_val  = '0;
    p4_valid = 1'b0; p4_reg = '0; p4_val = '0;
    c4_valid = 1'b0; c4_reg = '0; c4_val = '0;
    tick(); tick();
    chk("rst_we", rf_we, 0);
    chk("rst_waddr", rf_waddr, 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_ret", insts_ret, 0);
    chk("rst_plevel", pipe_level, 0);
    chk("rst_clevel", csr_level, 0);
    chk("rst_idle", idle, 1);
    rst = 1'b0;

    // Single pipe write: visible two edges after the push cycle.
    pipe_valid = 1'b1; pipe_reg = 5'd5; pipe_val = 32'hDEAD_BEEF;
    tick();
    pipe_valid = 1'b0;
    chk("single_we_c2", rf_we, 0);
    chk("single_plevel_c2", pipe_level, 1);
    chk("single_idle_c2", idle, 0);
    tick();
    chk("single_we_c3", rf_we, 1);
    chk("single_waddr_c3", rf_waddr, 5);
    chk("single_wdata_c3", rf_wdata, 32'hDEAD_BEEF);
    chk("single_ret_c3", insts_ret, 1);
    chk("single_idle_c3", idle, 0);
    tick();
    chk("single_we_c4", rf_we, 0);
    chk("single_ret_c4", insts_ret, 0);
    chk("single_idle_c4", idle, 1);
    chk("single_waddr_hold", rf_waddr, 5);

    // Both sources stream; full CSR FIFO forces CSR grants -> P,C alternation.
    pi = 0; ci = 0;
    for (int i = 0; i < 12; i++) begin
      pipe_valid = (i < 8); pipe_reg = 5'(1 + pi % 15); pipe_val = 32'h1000_0000 + 32'(pi);
      csr_valid  = (i < 8); csr_reg  = 5'(16 + ci % 16); csr_val = 32'h2000_0000 + 32'(ci);
      pr = pipe_ready; cr = csr_ready;
      tick();
      if (pipe_valid && pr) pi++;
      if (csr_valid && cr) ci++;
      e_we = (i >= 1) && (i <= 10);
      if (i % 2 == 1) begin
        k = (i - 1) / 2;
        e_addr = 5'(1 + k % 15); e_data = 32'h1000_0000 + 32'(k);
      end else begin
        k = i / 2 - 1;
        e_addr = 5'(16 + k % 16); e_data = 32'h2000_0000 + 32'(k);
      end
      chk($sformatf("stream_we_%0d", i), rf_we, e_we);
      if (e_we) begin
        chk($sformatf("stream_waddr_%0d", i), rf_waddr, e_addr);
        chk($sformatf("stream_wdata_%0d", i), rf_wdata, e_data);
      end
      if (i < 8) begin
        chk($sformatf("stream_pready_%0d", i), pipe_ready, (i == 0) || (i % 2 == 1));
        chk($sformatf("stream_cready_%0d", i), csr_ready, (i == 0) || (i % 2 == 0));
      end
    end
    chk("stream_idle_end", idle, 1);

    // One CSR entry against a continuous pipe stream: CSR wins after STARVE_LIMIT losses.
    pi = 0;
    for (int i = 0; i < 8; i++) begin
      pipe_valid = (i < 5); pipe_reg = 5'(1 + pi); pipe_val = 32'h3000_0000 + 32'(pi);
      csr_valid  = (i == 0); csr_reg = 5'd9; csr_val = 32'hC5C5_0000;
      pr = pipe_ready;
      tick();
      if (pipe_valid && pr) pi++;
      chk($sformatf("starve_we_%0d", i), rf_we, st_we[i]);
      if (st_we[i]) begin
        chk($sformatf("starve_waddr_%0d", i), rf_waddr, st_addr[i]);
        chk($sformatf("starve_wdata_%0d", i), rf_wdata, st_data[i]);
      end
    end
    pipe_valid = 1'b0; csr_valid = 1'b0;

    // Null pipe head plus CSR write head retire together.
    pipe_valid = 1'b1; pipe_reg = 5'd0; pipe_val = 32'h0000_0011;
    csr_valid  = 1'b1; csr_reg  = 5'd7; csr_val  = 32'h0000_0077;
    tick();
    pipe_valid = 1'b0; csr_valid = 1'b0;
    chk("null_ret_pre", insts_ret, 0);
    chk("null_levels_pre", {pipe_level, csr_level}, 4'b0101);
    tick();
    chk("null_ret", insts_ret, 2);
    chk("null_we", rf_we, 1);
    chk("null_waddr", rf_waddr, 7);
    chk("null_wdata", rf_wdata, 32'h77);
    chk("null_levels", {pipe_level, csr_level}, 0);
    tick();
    chk("null_ret_post", insts_ret, 0);

    // Reset with entries in flight discards them.
    pipe_valid = 1'b1; pipe_reg = 5'd3;  pipe_val = 32'hAAAA_0003;
    csr_valid  = 1'b1; csr_reg  = 5'd4;  csr_val  = 32'hBBBB_0004;
    tick();
    chk("rstq_levels", {pipe_level, csr_level}, 4'b0101);
    pipe_reg = 5'd10; csr_reg = 5'd11;
    rst = 1'b1;
    tick();
    rst = 1'b0; pipe_valid = 1'b0; csr_valid = 1'b0;
    chk("rstq_we", rf_we, 0);
    chk("rstq_ret", insts_ret, 0);
    chk("rstq_plevel", pipe_level, 0);
    chk("rstq_clevel", csr_level, 0);
    chk("rstq_waddr", rf_waddr, 0);
    chk("rstq_idle", idle, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("rstq_after_we_%0d", i), rf_we, 0);
      chk($sformatf("rstq_after_ret_%0d", i), insts_ret, 0);
    end

    // DEPTH=4 instance: alternating pushes through 10 pointer wraps per source.
    m_pl = 0; m_cl = 0;
    for (int i = 0; i < 81; i++) begin
      k = i / 2;
      p4_valid = (i < 80) && (i % 2 == 0); p4_reg = 5'(1 + k % 31); p4_val = 32'h4000_0000 + 32'(k);
      c4_valid = (i < 80) && (i % 2 == 1); c4_reg = 5'(1 + k % 31); c4_val = 32'h5000_0000 + 32'(k);
      // Only one source is ever non-empty here, so a non-empty head always pops.
      m_pl = m_pl + int'(p4_valid) - int'(m_pl != 0);
      m_cl = m_cl + int'(c4_valid) - int'(m_cl != 0);
      tick();
      chk($sformatf("d4_plevel_%0d", i), p4_level, m_pl);
      chk($sformatf("d4_clevel_%0d", i), c4_level, m_cl);
      chk($sformatf("d4_we_%0d", i), rf4_we, i >= 1);
      if (i >= 1) begin
        k = (i - 1) / 2;
        e_addr = 5'(1 + k % 31);
        e_data = ((i - 1) % 2 == 0) ? 32'h4000_0000 + 32'(k) : 32'h5000_0000 + 32'(k);
        chk($sformatf("d4_waddr_%0d", i), rf4_waddr, e_addr);
        chk($sformatf("d4_wdata_%0d", i), rf4_wdata, e_data);
      end
    end
    tick();
    chk("d4_idle_end", idle4, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
